iir_sample_pacer: RTL and testbench
===================================

Name: iir_sample_pacer

Overview:
Upstream feeder for the iir_sos biquad stage. It accepts fixed-point samples on a ready/valid stream and buffers them in a small FIFO. It re-issues them as single-cycle dv/d strobes spaced at least Gap clocks apart. This guarantees the biquad's multi-cycle MAC sequence finishes before the next sample arrives, so burst producers (ADC deserialisers, DMA readers) can drive the filter without knowing its timing.

Parameters:
Ndint, 3, integer bits of sample word (matches iir_sos Ndint)
Ndfrac, 22, fractional bits of sample word (matches iir_sos Ndfrac)
Gap, 7, minimum clock count from one dv_out strobe to the next; legal range 1..255; 1 = back-to-back allowed
Depth, 8, FIFO entries; power of two, 2..256

Ports:
clk  in  1  system clock, all logic rising-edge
reset  in  1  asynchronous, active-high reset
flush  in  1  synchronous clear of FIFO and pacing counter
s_valid  in  1  upstream sample valid
s_ready  out  1  pacer can accept a sample this cycle
s_data  in  [Ndint-1:-Ndfrac]  upstream sample, signed fixed point
dv_out  out  1  one-cycle strobe, connects to iir_sos dv_in
d_out  out  [Ndint-1:-Ndfrac]  sample, connects to iir_sos d_in; held stable between strobes
level  out  $clog2(Depth)+1  current FIFO occupancy, 0..Depth
overflow_cnt  out  16  count of cycles with s_valid=1 and s_ready=0; saturates at 16'hFFFF

Behaviour:
- Reset is asynchronous and active-high. While reset is asserted: FIFO empty, level=0, dv_out=0, d_out=0, pace counter=0, overflow_cnt=0, s_ready=0. s_ready rises on the first clk edge after reset deasserts.
- Accept: a sample is written when s_valid && s_ready at a clk edge. s_ready = !full, registered-free. When full, no write occurs even if a read happens in the same cycle; ready returns the cycle after level drops.
- Pace counter: issue is allowed when counter==0. On issue, counter loads Gap-1, then decrements by 1 per clock to 0.
- Issue: at a clk edge where FIFO is non-empty and counter==0:
  - pop the head into d_out;
  - dv_out=1 for exactly that following cycle;
  - otherwise dv_out=0 and d_out holds its last value.
- Latency: a sample accepted at edge k into an empty FIFO with counter==0 is issued at edge k+1. dv_out is therefore high in the cycle after the accept cycle.
- Steady-state spacing: a continuously non-empty FIFO gives exactly one dv_out every Gap clocks. With Gap=1, dv_out stays high continuously.
- Simultaneous write and issue on a non-full FIFO: both occur and level is unchanged. Write into an empty FIFO plus issue in the same cycle is not a same-cycle bypass; the new entry issues on a later edge.
- level counts write and read in the same edge as net 0. Its maximum is Depth.
- Pointers are $clog2(Depth) bits and wrap modulo Depth. Full/empty are derived from level.
- overflow_cnt increments on each cycle with s_valid && !s_ready, and saturates at 16'hFFFF. It is cleared by reset only; flush does not clear it.
- flush (synchronous, highest priority over accept and issue):
  - next edge: level=0, pointers=0, counter=0, dv_out=0;
  - d_out retains its value;
  - a sample presented during the flush cycle is dropped, and s_ready stays high if the FIFO was not full.
- Reset asserted mid-burst takes effect immediately (asynchronous). Any pending dv_out is cancelled in the same cycle.
- No arithmetic is done on sample data; bits pass through unmodified.

Decomposition:
- Shared package iir_pkg holds:
  - typedef for sample word logic signed [Ndint-1:-Ndfrac];
  - function clog2-based width helpers;
  - constant OVF_CNT_W=16.
  The same package is later reused by iir_sos wrappers.
- One sub-module, iir_fifo_sync: single-clock FIFO, parameters Width/Depth, with wr_en, rd_en, level, full, empty, and asynchronous reset. The pacer top holds the pace counter, issue logic, output registers and overflow counter.

Test Plan:
- Reset then single sample 0x0000001 with Gap=7 -> dv_out high exactly one cycle, on the edge after acceptance; d_out=0x0000001 and held; level returns to 0.
- Burst of 8 samples 1..8 on consecutive cycles, Depth=8 -> all accepted with s_ready never low. dv_out strobes are spaced exactly 7 clocks, d_out=1..8 in order, overflow_cnt=0.
- Burst of 12 samples back-to-back with s_valid held -> s_ready drops when level=8. overflow_cnt counts the stalled cycles, no sample is lost, and output order is 1..12.
- Gap=1 parameterisation, 4 back-to-back samples -> dv_out high 4 consecutive cycles, d_out=1,2,3,4.
- flush asserted with level=5 mid-pacing -> next cycle level=0 and dv_out=0, with no further strobes. d_out keeps its last issued value, and a new sample after flush issues one edge after acceptance.
- Asynchronous reset pulse between clk edges while dv_out=1 -> dv_out, level and overflow_cnt go to 0 immediately, without waiting for a clk edge.

Source files
------------

// File: rtl/iir_pkg.sv
// Shared types and width helpers for the iir_sos front-end blocks.
package iir_pkg;

  localparam int NDINT     = 3;
  localparam int NDFRAC    = 22;
  localparam int OVF_CNT_W = 16;

  typedef logic signed [NDINT-1:-NDFRAC] sample_t;

  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic int level_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/iir_fifo_sync.sv
// Single-clock FIFO with occupancy level; full/empty derive from the level count.
module iir_fifo_sync
  import iir_pkg::*;
#(
  parameter int Width = 25,
  parameter int Depth = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          clr,
  input  logic                          wr_en,
  input  logic [Width-1:0]              wr_data,
  input  logic                          rd_en,
  output logic [Width-1:0]              rd_data,
  output logic [level_width(Depth)-1:0] level,
  output logic                          full,
  output logic                          empty
);

  localparam int PW = ptr_width(Depth);
  localparam int LW = level_width(Depth);
  localparam logic [LW-1:0] DEPTH_LVL = LW'(Depth);

  logic [Width-1:0] mem_q [Depth];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic             do_wr_s, do_rd_s;

  assign full    = (level_q == DEPTH_LVL);
  assign empty   = (level_q == {LW{1'b0}});
  assign level   = level_q;
  assign rd_data = mem_q[rd_ptr_q];
  assign do_wr_s = wr_en && !full && !clr;
  assign do_rd_s = rd_en && !empty && !clr;

  // Pointer and level next state; pointers wrap naturally at a power-of-two depth.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (clr) begin
      wr_ptr_d = {PW{1'b0}};
      rd_ptr_d = {PW{1'b0}};
      level_d  = {LW{1'b0}};
    end else begin
      if (do_wr_s) wr_ptr_d = wr_ptr_q + PW'(1);
      else         wr_ptr_d = wr_ptr_q;
      if (do_rd_s) rd_ptr_d = rd_ptr_q + PW'(1);
      else         rd_ptr_d = rd_ptr_q;
      case ({do_wr_s, do_rd_s})
        2'b10:   level_d = level_q + LW'(1);
        2'b01:   level_d = level_q - LW'(1);
        default: level_d = level_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= {PW{1'b0}};
      rd_ptr_q <= {PW{1'b0}};
      level_q  <= {LW{1'b0}};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage array carries no reset; entries are only read once written.
  always_ff @(posedge clk) begin
    if (do_wr_s) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/iir_sample_pacer.sv
// Buffers a ready/valid sample stream and re-issues it as dv/d strobes at least Gap clocks apart.
module iir_sample_pacer
  import iir_pkg::*;
#(
  parameter int Ndint  = NDINT,
  parameter int Ndfrac = NDFRAC,
  parameter int Gap    = 7,
  parameter int Depth  = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          flush,
  input  logic                          s_valid,
  output logic                          s_ready,
  input  logic signed [Ndint-1:-Ndfrac] s_data,
  output logic                          dv_out,
  output logic signed [Ndint-1:-Ndfrac] d_out,
  output logic [level_width(Depth)-1:0] level,
  output logic [OVF_CNT_W-1:0]          overflow_cnt
);

  localparam int W  = Ndint + Ndfrac;
  localparam int CW = 8;
  localparam logic [CW-1:0] GAP_RELOAD = CW'(Gap - 1);

  logic [W-1:0]         fifo_rd_data_s;
  logic                 fifo_full_s, fifo_empty_s;
  logic                 wr_en_s, issue_s;
  logic                 ready_en_q;
  logic [CW-1:0]        pace_q, pace_d;
  logic                 dv_q, dv_d;
  logic [W-1:0]         d_q, d_d;
  logic [OVF_CNT_W-1:0] ovf_q, ovf_d;

  // ready_en_q keeps s_ready low until the first edge after reset is released.
  assign s_ready      = ready_en_q && !fifo_full_s;
  assign wr_en_s      = s_valid && s_ready;
  assign issue_s      = !fifo_empty_s && (pace_q == {CW{1'b0}}) && !flush;
  assign dv_out       = dv_q;
  assign d_out        = d_q;
  assign overflow_cnt = ovf_q;

  iir_fifo_sync #(
    .Width (W),
    .Depth (Depth)
  ) u_fifo (
    .clk     (clk),
    .rst     (reset),
    .clr     (flush),
    .wr_en   (wr_en_s),
    .wr_data (s_data),
    .rd_en   (issue_s),
    .rd_data (fifo_rd_data_s),
    .level   (level),
    .full    (fifo_full_s),
    .empty   (fifo_empty_s)
  );

  // Pacing, issue and overflow next state; flush dominates but leaves d_out and the counter of stalls alone.
  always_comb begin
    pace_d = pace_q;
    dv_d   = 1'b0;
    d_d    = d_q;
    ovf_d  = ovf_q;
    if (flush) begin
      pace_d = {CW{1'b0}};
    end else if (issue_s) begin
      pace_d = GAP_RELOAD;
      dv_d   = 1'b1;
      d_d    = fifo_rd_data_s;
    end else if (pace_q != {CW{1'b0}}) begin
      pace_d = pace_q - CW'(1);
    end else begin
      pace_d = pace_q;
    end
    if (s_valid && !s_ready && (ovf_q != {OVF_CNT_W{1'b1}})) ovf_d = ovf_q + OVF_CNT_W'(1);
    else                                                     ovf_d = ovf_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ready_en_q <= 1'b0;
      pace_q     <= {CW{1'b0}};
      dv_q       <= 1'b0;
      d_q        <= {W{1'b0}};
      ovf_q      <= {OVF_CNT_W{1'b0}};
    end else begin
      ready_en_q <= 1'b1;
      pace_q     <= pace_d;
      dv_q       <= dv_d;
      d_q        <= d_d;
      ovf_q      <= ovf_d;
    end
  end

endmodule

// File: tb/tb_iir_sample_pacer.sv
// Directed bench for iir_sample_pacer: Gap=7 instance for most scenarios, Gap=1 instance for back-to-back issue.
module tb_iir_sample_pacer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               reset, flush, s_valid, s_ready, dv_out;
  logic signed [2:-22] s_data, d_out;
  logic [3:0]         level;
  logic [15:0]        overflow_cnt;

  logic               g1_flush, g1_valid, g1_ready, g1_dv;
  logic signed [2:-22] g1_data, g1_dout;
  logic [3:0]         g1_level;
  logic [15:0]        g1_ovf;

  int compared   = 0;
  int mismatched = 0;

  iir_sample_pacer #(.Ndint(3), .Ndfrac(22), .Gap(7), .Depth(8)) dut (
    .clk(clk), .reset(reset), .flush(flush), .s_valid(s_valid), .s_ready(s_ready),
    .s_data(s_data), .dv_out(dv_out), .d_out(d_out), .level(level), .overflow_cnt(overflow_cnt)
  );

  iir_sample_pacer #(.Ndint(3), .Ndfrac(22), .Gap(1), .Depth(8)) dut_g1 (
    .clk(clk), .reset(reset), .flush(g1_flush), .s_valid(g1_valid), .s_ready(g1_ready),
    .s_data(g1_data), .dv_out(g1_dv), .d_out(g1_dout), .level(g1_level), .overflow_cnt(g1_ovf)
  );

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1; flush = 1'b0; s_valid = 1'b0; s_data = '0;
    g1_flush = 1'b0; g1_valid = 1'b0; g1_data = '0;
    #2;
    compared++; if (dv_out !== 1'b0) begin mismatched++; $display("FAIL reset_dv: got %0b want 0", dv_out); end
    compared++; if (level !== 4'd0) begin mismatched++; $display("FAIL reset_level: got %0d want 0", level); end
    compared++; if (overflow_cnt !== 16'd0) begin mismatched++; $display("FAIL reset_ovf: got %0d want 0", overflow_cnt); end
    compared++; if (s_ready !== 1'b0) begin mismatched++; $display("FAIL reset_ready: got %0b want 0", s_ready); end
    compared++; if (d_out !== 25'sd0) begin mismatched++; $display("FAIL reset_dout: got %0h want 0", d_out); end
    @(negedge clk);
    reset = 1'b0;
    #1;
    compared++; if (s_ready !== 1'b0) begin mismatched++; $display("FAIL ready_before_edge: got %0b want 0", s_ready); end
    @(posedge clk); #1;
    compared++; if (s_ready !== 1'b1) begin mismatched++; $display("FAIL ready_after_edge: got %0b want 1", s_ready); end
    @(negedge clk);
  endtask

  task automatic test_single();
    int strobes;
    s_valid = 1'b1; s_data = 25'sd1;
    compared++; if (s_ready !== 1'b1) begin mismatched++; $display("FAIL single_ready: got %0b want 1", s_ready); end
    tick();
    s_valid = 1'b0;
    compared++; if (level !== 4'd1) begin mismatched++; $display("FAIL single_level1: got %0d want 1", level); end
    compared++; if (dv_out !== 1'b0) begin mismatched++; $display("FAIL single_dv_early: got %0b want 0", dv_out); end
    tick();
    compared++; if (dv_out !== 1'b1) begin mismatched++; $display("FAIL single_dv: got %0b want 1", dv_out); end
    compared++; if (d_out !== 25'sd1) begin mismatched++; $display("FAIL single_dout: got %0h want 1", d_out); end
    compared++; if (level !== 4'd0) begin mismatched++; $display("FAIL single_level0: got %0d want 0", level); end
    strobes = 0;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (dv_out) strobes++;
    end
    compared++; if (strobes !== 0) begin mismatched++; $display("FAIL single_extra_strobes: got %0d want 0", strobes); end
    compared++; if (d_out !== 25'sd1) begin mismatched++; $display("FAIL single_hold: got %0h want 1", d_out); end
  endtask

  task automatic test_burst8();
    int nexp, last, nstrobe, ready_low;
    nexp = 1; last = -1; nstrobe = 0; ready_low = 0;
    for (int c = 0; c < 64; c++) begin
      if (c < 8) begin
        s_valid = 1'b1; s_data = 25'(c + 1);
        if (!s_ready) ready_low++;
      end else begin
        s_valid = 1'b0;
      end
      tick();
      if (dv_out) begin
        compared++; if (d_out !== 25'(nexp)) begin mismatched++; $display("FAIL burst8_data: got %0d want %0d", d_out, nexp); end
        if (last < 0) begin
          compared++; if (c !== 1) begin mismatched++; $display("FAIL burst8_latency: got cycle %0d want 1", c); end
        end else begin
          compared++; if (c - last !== 7) begin mismatched++; $display("FAIL burst8_spacing: got %0d want 7", c - last); end
        end
        last = c; nexp++; nstrobe++;
      end
    end
    s_valid = 1'b0;
    compared++; if (nstrobe !== 8) begin mismatched++; $display("FAIL burst8_count: got %0d want 8", nstrobe); end
    compared++; if (ready_low !== 0) begin mismatched++; $display("FAIL burst8_ready_low: got %0d want 0", ready_low); end
    compared++; if (overflow_cnt !== 16'd0) begin mismatched++; $display("FAIL burst8_ovf: got %0d want 0", overflow_cnt); end
  endtask

  task automatic test_overflow12();
    int sent, nexp, nstrobe, max_lvl;
    bit acc, first_stall;
    sent = 0; nexp = 1; nstrobe = 0; max_lvl = 0; first_stall = 1'b1;
    for (int c = 0; c < 100; c++) begin
      if (sent < 12) begin s_valid = 1'b1; s_data = 25'(sent + 1); end
      else           s_valid = 1'b0;
      #1;
      acc = s_valid && s_ready;
      if (s_valid && !s_ready && first_stall) begin
        first_stall = 1'b0;
        compared++; if (level !== 4'd8) begin mismatched++; $display("FAIL ovf_stall_level: got %0d want 8", level); end
      end
      tick();
      if (acc) sent++;
      if (int'(level) > max_lvl) max_lvl = int'(level);
      if (dv_out) begin
        compared++; if (d_out !== 25'(nexp)) begin mismatched++; $display("FAIL ovf_order: got %0d want %0d", d_out, nexp); end
        nexp++; nstrobe++;
      end
    end
    s_valid = 1'b0;
    compared++; if (sent !== 12) begin mismatched++; $display("FAIL ovf_sent: got %0d want 12", sent); end
    compared++; if (nstrobe !== 12) begin mismatched++; $display("FAIL ovf_strobes: got %0d want 12", nstrobe); end
    compared++; if (max_lvl !== 8) begin mismatched++; $display("FAIL ovf_max_level: got %0d want 8", max_lvl); end
    compared++; if (overflow_cnt !== 16'd12) begin mismatched++; $display("FAIL ovf_count: got %0d want 12", overflow_cnt); end
  endtask

  task automatic test_back_to_back();
    bit exp_dv;
    for (int c = 0; c < 10; c++) begin
      if (c < 4) begin g1_valid = 1'b1; g1_data = 25'(c + 1); end
      else       g1_valid = 1'b0;
      tick();
      exp_dv = (c >= 1) && (c <= 4);
      compared++; if (g1_dv !== exp_dv) begin mismatched++; $display("FAIL gap1_dv c%0d: got %0b want %0b", c, g1_dv, exp_dv); end
      if (exp_dv) begin
        compared++; if (g1_dout !== 25'(c)) begin mismatched++; $display("FAIL gap1_data: got %0d want %0d", g1_dout, c); end
      end
    end
  endtask

  task automatic test_flush();
    int strobes;
    for (int c = 0; c < 6; c++) begin
      s_valid = 1'b1; s_data = 25'(10 + c);
      tick();
    end
    s_valid = 1'b0;
    compared++; if (level !== 4'd5) begin mismatched++; $display("FAIL flush_pre_level: got %0d want 5", level); end
    flush = 1'b1; s_valid = 1'b1; s_data = 25'h0000055;
    #1;
    compared++; if (s_ready !== 1'b1) begin mismatched++; $display("FAIL flush_ready: got %0b want 1", s_ready); end
    tick();
    flush = 1'b0; s_valid = 1'b0;
    compared++; if (level !== 4'd0) begin mismatched++; $display("FAIL flush_level: got %0d want 0", level); end
    compared++; if (dv_out !== 1'b0) begin mismatched++; $display("FAIL flush_dv: got %0b want 0", dv_out); end
    compared++; if (d_out !== 25'sd10) begin mismatched++; $display("FAIL flush_dout: got %0d want 10", d_out); end
    compared++; if (overflow_cnt !== 16'd12) begin mismatched++; $display("FAIL flush_ovf_kept: got %0d want 12", overflow_cnt); end
    strobes = 0;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (dv_out) strobes++;
    end
    compared++; if (strobes !== 0) begin mismatched++; $display("FAIL flush_strobes: got %0d want 0", strobes); end
    s_valid = 1'b1; s_data = 25'h1ABCDEF;
    tick();
    s_valid = 1'b0;
    compared++; if (dv_out !== 1'b0) begin mismatched++; $display("FAIL post_flush_early: got %0b want 0", dv_out); end
    tick();
    compared++; if (dv_out !== 1'b1) begin mismatched++; $display("FAIL post_flush_dv: got %0b want 1", dv_out); end
    compared++; if (d_out !== 25'h1ABCDEF) begin mismatched++; $display("FAIL post_flush_data: got %0h want 1abcdef", d_out); end
    for (int c = 0; c < 8; c++) tick();
    // flush right after an issue must also clear the pace counter
    s_valid = 1'b1; s_data = 25'sd40;
    tick();
    s_valid = 1'b0;
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0; s_valid = 1'b1; s_data = 25'sd41;
    tick();
    s_valid = 1'b0;
    tick();
    compared++; if (dv_out !== 1'b1) begin mismatched++; $display("FAIL flush_pace_clear_dv: got %0b want 1", dv_out); end
    compared++; if (d_out !== 25'sd41) begin mismatched++; $display("FAIL flush_pace_clear_data: got %0d want 41", d_out); end
    for (int c = 0; c < 8; c++) tick();
  endtask

  task automatic test_async_reset();
    s_valid = 1'b1; s_data = 25'sd21;
    tick();
    s_data = 25'sd22;
    tick();
    s_valid = 1'b0;
    compared++; if (dv_out !== 1'b1) begin mismatched++; $display("FAIL arst_pre_dv: got %0b want 1", dv_out); end
    compared++; if (level !== 4'd1) begin mismatched++; $display("FAIL arst_pre_level: got %0d want 1", level); end
    #2 reset = 1'b1;
    #1;
    compared++; if (dv_out !== 1'b0) begin mismatched++; $display("FAIL arst_dv: got %0b want 0", dv_out); end
    compared++; if (level !== 4'd0) begin mismatched++; $display("FAIL arst_level: got %0d want 0", level); end
    compared++; if (overflow_cnt !== 16'd0) begin mismatched++; $display("FAIL arst_ovf: got %0d want 0", overflow_cnt); end
    compared++; if (d_out !== 25'sd0) begin mismatched++; $display("FAIL arst_dout: got %0d want 0", d_out); end
    @(negedge clk);
    reset = 1'b0;
    tick();
    compared++; if (s_ready !== 1'b1) begin mismatched++; $display("FAIL arst_ready_back: got %0b want 1", s_ready); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_burst8();
    test_overflow12();
    test_back_to_back();
    test_flush();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
